// File: rtl/prog_ctr.sv
// Program counter / fetch sequencer: holds PC, runs IDLE/RUN/HALT, counts retired instructions.
module prog_ctr #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic             branch_i,
  input  logic [7:0]       boffset_i,
  input  logic             bsign_i,
  input  logic             sreset_i,
  input  logic             shalt_i,
  input  logic             stall_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] icount_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             running_q, done_q;

  logic [PC_W-1:0]  boff_ext;
  logic [CNT_W-1:0] icount_inc;

  // Offset zero-extends into PC width; counter increment saturates at all-ones.
  always_comb begin
    boff_ext   = PC_W'(boffset_i);
    icount_inc = (icount_q == {CNT_W{1'b1}}) ? icount_q : icount_q + CNT_W'(1);
  end

  // Next-state, next-PC and next-count; first matching RUN row wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d  = ST_RUN;
          pc_d     = start_addr_i;
          icount_d = '0;
        end
      end
      ST_RUN: begin
        if (start_i) begin
          pc_d     = start_addr_i;
          icount_d = '0;
        end else if (sreset_i && shalt_i) begin
          state_d  = ST_HALT;
          icount_d = icount_inc;
        end else if (sreset_i) begin
          pc_d     = '0;
          icount_d = icount_inc;
        end else if (stall_i) begin
          pc_d     = pc_q;
        end else if (branch_i && !bsign_i) begin
          pc_d     = pc_q + boff_ext;
          icount_d = icount_inc;
        end else if (branch_i) begin
          pc_d     = pc_q - boff_ext;
          icount_d = icount_inc;
        end else begin
          pc_d     = pc_q + PC_W'(1);
          icount_d = icount_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC, counter and decoded status flags, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      icount_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      icount_q  <= icount_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_HALT);
    end
  end

  assign pc_o      = pc_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign icount_o  = icount_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed self-checking bench for prog_ctr.
module tb_prog_ctr;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic             branch_i;
  logic [7:0]       boffset_i;
  logic             bsign_i;
  logic             sreset_i;
  logic             shalt_i;
  logic             stall_i;
  logic [PC_W-1:0]  pc_o;
  logic             running_o;
  logic             done_o;
  logic [CNT_W-1:0] icount_o;

  int checks;
  int errors;

  prog_ctr #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .branch_i     (branch_i),
    .boffset_i    (boffset_i),
    .bsign_i      (bsign_i),
    .sreset_i     (sreset_i),
    .shalt_i      (shalt_i),
    .stall_i      (stall_i),
    .pc_o         (pc_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .icount_o     (icount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    start_addr_i = '0;
    branch_i     = 1'b0;
    boffset_i    = 8'd0;
    bsign_i      = 1'b0;
    sreset_i     = 1'b0;
    shalt_i      = 1'b0;
    stall_i      = 1'b0;
  endtask

  task automatic do_start(input logic [PC_W-1:0] addr);
    idle_inputs();
    start_i      = 1'b1;
    start_addr_i = addr;
    step();
    start_i      = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [PC_W-1:0] epc,
                             input logic erun, input logic edone,
                             input logic [CNT_W-1:0] ecnt);
    checks++;
    if (pc_o !== epc || running_o !== erun || done_o !== edone || icount_o !== ecnt) begin
      errors++;
      $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, expected pc=%h run=%b done=%b cnt=%0d",
               name, pc_o, running_o, done_o, icount_o, epc, erun, edone, ecnt);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    check_state("reset_init", 10'h000, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    // IDLE ignores everything but START
    branch_i = 1'b1; boffset_i = 8'd3; sreset_i = 1'b1; stall_i = 1'b1;
    step(); step();
    check_state("idle_ignores", 10'h000, 1'b0, 1'b0, 16'd0);
    do_start(10'h058);
    step(); step();
    check_state("pre_async_rst", 10'h05A, 1'b1, 1'b0, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 10'h000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_state("post_rst_idle", 10'h000, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_sequential();
    logic [PC_W-1:0] exp_pc;
    do_start(10'h010);
    check_state("seq_start", 10'h010, 1'b1, 1'b0, 16'd0);
    exp_pc = 10'h010;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = exp_pc + 10'd1;
      check_state("seq_step", exp_pc, 1'b1, 1'b0, CNT_W'(i));
    end
  endtask

  task automatic test_branch();
    do_start(10'h020);
    branch_i = 1'b1; boffset_i = 8'h07; bsign_i = 1'b0;
    step();
    check_state("branch_fwd", 10'h027, 1'b1, 1'b0, 16'd1);
    boffset_i = 8'h0A; bsign_i = 1'b1;
    step();
    check_state("branch_back", 10'h01D, 1'b1, 1'b0, 16'd2);
    boffset_i = 8'h00; bsign_i = 1'b0;
    step();
    check_state("branch_self", 10'h01D, 1'b1, 1'b0, 16'd3);
    boffset_i = 8'hFF; bsign_i = 1'b0;
    step();
    check_state("branch_ff", 10'h11C, 1'b1, 1'b0, 16'd4);
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_start(10'h3FE);
    branch_i = 1'b1; boffset_i = 8'h05; bsign_i = 1'b0;
    step();
    check_state("wrap_fwd", 10'h003, 1'b1, 1'b0, 16'd1);
    do_start(10'h002);
    branch_i = 1'b1; boffset_i = 8'h04; bsign_i = 1'b1;
    step();
    check_state("wrap_back", 10'h3FE, 1'b1, 1'b0, 16'd1);
    idle_inputs();
    do_start(10'h3FF);
    step();
    check_state("wrap_plain", 10'h000, 1'b1, 1'b0, 16'd1);
  endtask

  task automatic test_priority();
    do_start(10'h040);
    sreset_i = 1'b1; shalt_i = 1'b1; stall_i = 1'b1; branch_i = 1'b1; boffset_i = 8'h05;
    step();
    check_state("halt_enter", 10'h040, 1'b0, 1'b1, 16'd1);
    shalt_i = 1'b0; bsign_i = 1'b1;
    step(); step();
    check_state("halt_frozen", 10'h040, 1'b0, 1'b1, 16'd1);
    do_start(10'h000);
    check_state("halt_restart", 10'h000, 1'b1, 1'b0, 16'd0);
    // START outranks SRESET/SHALT in RUN
    start_i = 1'b1; start_addr_i = 10'h155; sreset_i = 1'b1; shalt_i = 1'b1;
    step();
    check_state("start_wins", 10'h155, 1'b1, 1'b0, 16'd0);
    idle_inputs();
  endtask

  task automatic test_stall_sreset();
    do_start(10'h033);
    stall_i = 1'b1; branch_i = 1'b1; boffset_i = 8'h09;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall_hold", 10'h033, 1'b1, 1'b0, 16'd0);
    end
    sreset_i = 1'b1; shalt_i = 1'b0;
    step();
    check_state("soft_reset", 10'h000, 1'b1, 1'b0, 16'd1);
    idle_inputs();
    step();
    check_state("after_soft", 10'h001, 1'b1, 1'b0, 16'd2);
  endtask

  task automatic test_saturate();
    do_start(10'h000);
    repeat (65535) step();
    check_state("cnt_max", 10'h3FF, 1'b1, 1'b0, 16'hFFFF);
    step(); step();
    check_state("cnt_sat", 10'h001, 1'b1, 1'b0, 16'hFFFF);
    do_start(10'h004);
    check_state("cnt_clear", 10'h004, 1'b1, 1'b0, 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_priority();
    test_stall_sreset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
